debug_memory_dumper: RTL and testbench
======================================

# debug_memory_dumper

Debug-side reader for the data memory of the MEMORY stage. On a start pulse it sweeps the memory's debug read port across all TAM words, captures each word, and streams it byte-by-byte to the debug UART transmitter over a valid/ready handshake. It sits in the debug unit, between the pipeline's debug address/data port and the UART TX. It is the initiator that drives the debug address that the MEMORY stage only answers.

## Interface
Parameters:
- NB, 32, data word width; must be a multiple of 8
- TAM, 16, number of memory words to dump
- ADDR_STEP, 1, debug-address increment per word (1 = word index, 4 = byte address)

Ports:
- i_clk  in  1  single clock; all state changes on its rising edge
- i_reset  in  1  asynchronous, active-low reset (0 = reset)
- i_start  in  1  request a full dump; sampled only in IDLE
- o_debug_address  out  NB  address presented to the memory debug read port
- i_debug_data  in  NB  word returned by the memory debug read port
- o_tx_data  out  8  byte to the UART TX
- o_tx_valid  out  1  o_tx_data is valid
- i_tx_ready  in  1  UART TX accepts the byte this cycle
- o_busy  out  1  dump in progress (every state except IDLE)
- o_done  out  1  one-cycle pulse when the dump completes

## Operation
- FSM states: IDLE, SET_ADDR, SEND, DONE (plus CHECKSUM when configured).
- IDLE:
  - o_debug_address = 0; word index = 0.
  - i_start=1 moves to SET_ADDR.
- SET_ADDR:
  - o_debug_address = index*ADDR_STEP, registered and stable for the whole cycle.
  - The memory read is combinational or single-cycle. i_debug_data is latched into the word register on the edge leaving SET_ADDR.
  - Byte counter is set to NB/8-1.
  - Next state is always SEND.
- SEND:
  - o_tx_valid=1; o_tx_data = latched word byte selected by the byte counter. Order is MSB byte first.
  - A byte transfers on an edge with o_tx_valid & i_tx_ready.
  - While ready is low, o_tx_valid and o_tx_data hold unchanged.
  - After the last byte (counter 0) transfers:
    - If index == TAM-1, go to DONE (or CHECKSUM when configured).
    - Otherwise increment index and go to SET_ADDR.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- i_start is ignored in every state except IDLE. A start held high through DONE begins a new dump one cycle after returning to IDLE.
- Index width is clog2(TAM). Address arithmetic is NB bits and truncates silently (unsigned).
- Reset, including mid-dump, asynchronously forces:
  - state IDLE; index 0
  - o_debug_address=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0
  - checksum register 0
  
  A byte in flight is abandoned.

## Timing
- Reset values: all outputs 0.
- Start sampled at edge t0. o_busy=1 and SET_ADDR address valid from t0+1. First o_tx_valid from t0+2.
- With i_tx_ready held high:
  - Each word costs 1 + NB/8 cycles.
  - Dump length is TAM*(1+NB/8) cycles, followed by 1 DONE cycle (+1 CHECKSUM cycle when enabled).
  - Default parameters: 80 cycles + DONE.
- o_tx_valid never deasserts without a completed handshake, except on reset.
- o_tx_valid is low in SET_ADDR, so there is a one-cycle bubble between words.

## Configuration
- DEBUG_DUMP_CHECKSUM_EN defined:
  - A running XOR of every transmitted byte is kept; it is cleared on leaving IDLE.
  - After the last data byte, state CHECKSUM sends it as one extra byte under the same handshake, then goes to DONE.
- Not defined: no checksum register or state. The last data byte goes straight to DONE.

## Structure
- Shared debug package holds:
  - the FSM state encoding (localparam/typedef for IDLE, SET_ADDR, SEND, DONE, CHECKSUM)
  - the byte width constant (8)
  - the clog2-based index-width function
- One sub-module is natural: debug_byte_serializer. It latches an NB-bit word and emits NB/8 bytes MSB-first with the valid/ready handshake and byte counter. The top FSM handles addressing and sequencing.

## Test plan
- TAM=4, NB=32, memory word i = 0x11223344+i, i_tx_ready=1, pulse i_start → 16 bytes:
  - 11 22 33 44 11 22 33 45 11 22 33 46 11 22 33 47
  - o_done high exactly at cycle t0+21.
- ADDR_STEP=4, same memory → o_debug_address sequence 0, 4, 8, 12; one SET_ADDR cycle each.
- i_tx_ready toggling 1,0,0,1 pseudo-randomly → byte stream identical to the first test; o_tx_data/o_tx_valid stable during every not-ready cycle.
- Reset asserted while sending byte 2 of word 1 → all outputs 0 immediately. Next start dumps from address 0.
- i_start pulsed mid-dump and held high through DONE → no restart mid-dump; the second dump begins one cycle after IDLE.
- DEBUG_DUMP_CHECKSUM_EN with the first test's data → 17th byte = XOR of all 16 bytes = 0x00; o_done one cycle later.

Source files
------------

// File: rtl/debug_memory_dumper_pkg.sv
// Shared debug-unit definitions: dumper FSM encoding, byte width and index sizing.
// The optional DEBUG_DUMP_CHECKSUM_EN build uses the ST_CHECKSUM state.
package debug_memory_dumper_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SET_ADDR = 3'd1,
    ST_SEND     = 3'd2,
    ST_DONE     = 3'd3,
    ST_CHECKSUM = 3'd4
  } dump_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debug_byte_serializer.sv
// Latches one NB-bit word and emits it MSB byte first over a valid/ready link.
// i_single loads just the low byte (used for the trailing checksum byte).
module debug_byte_serializer
  import debug_memory_dumper_pkg::*;
#(
  parameter int NB = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic          i_single,
  input  logic [NB-1:0] i_word,
  input  logic          i_tx_ready,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  output logic          o_xfer,
  output logic          o_last_xfer
);

  localparam int NBYTES = NB / BYTE_W;
  localparam int CW     = idx_width(NBYTES);

  logic [NB-1:0] word_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_m1;

  // A byte moves on any edge where valid and ready are both high.
  assign o_xfer      = o_tx_valid & i_tx_ready;
  assign o_last_xfer = o_xfer && (cnt == '0);
  assign cnt_m1      = cnt - 1'b1;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      word_q     <= '0;
      cnt        <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
    end else if (i_load) begin
      word_q     <= i_word;
      o_tx_valid <= 1'b1;
      if (i_single) begin
        cnt       <= '0;
        o_tx_data <= i_word[BYTE_W-1:0];
      end else begin
        cnt       <= CW'(NBYTES - 1);
        o_tx_data <= i_word[NB-1 -: BYTE_W];
      end
    end else if (o_xfer) begin
      if (cnt == '0) begin
        o_tx_valid <= 1'b0;
      end else begin
        cnt       <= cnt_m1;
        o_tx_data <= word_q[{cnt_m1, 3'b000} +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/debug_memory_dumper.sv
// Sweeps the data-memory debug port over TAM words and streams them to the UART TX.
// Define DEBUG_DUMP_CHECKSUM_EN to append an XOR checksum byte after the data.
module debug_memory_dumper
  import debug_memory_dumper_pkg::*;
#(
  parameter int NB        = 32,
  parameter int TAM       = 16,
  parameter int ADDR_STEP = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  output logic [NB-1:0] o_debug_address,
  input  logic [NB-1:0] i_debug_data,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic          o_busy,
  output logic          o_done
);

  localparam int IW = idx_width(TAM);

  // Handshake: a byte transfers on a rising edge with o_tx_valid & i_tx_ready;
  // once raised, o_tx_valid and o_tx_data hold until that transfer (or reset).
  dump_state_t   state;
  logic [IW-1:0] idx;
  logic          last_word;
  logic          ser_load;
  logic          ser_single;
  logic [NB-1:0] ser_word;
  logic          ser_xfer;
  logic          ser_last;

  assign last_word = (idx == IW'(TAM - 1));

`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [7:0] chk_q;
  logic [7:0] chk_next;

  // The checksum byte is loaded on the same edge the last data byte leaves.
  assign chk_next   = chk_q ^ o_tx_data;
  assign ser_load   = (state == ST_SET_ADDR) || ((state == ST_SEND) && ser_last && last_word);
  assign ser_single = (state == ST_SEND);
  assign ser_word   = (state == ST_SEND) ? NB'(chk_next) : i_debug_data;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      chk_q <= '0;
    end else if ((state == ST_IDLE) && i_start) begin
      chk_q <= '0;
    end else if ((state == ST_SEND) && ser_xfer) begin
      chk_q <= chk_next;
    end
  end
`else
  assign ser_load   = (state == ST_SET_ADDR);
  assign ser_single = 1'b0;
  assign ser_word   = i_debug_data;
`endif

  debug_byte_serializer #(.NB(NB)) u_serializer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (ser_load),
    .i_single    (ser_single),
    .i_word      (ser_word),
    .i_tx_ready  (i_tx_ready),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .o_xfer      (ser_xfer),
    .o_last_xfer (ser_last)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state           <= ST_IDLE;
      idx             <= '0;
      o_debug_address <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state  <= ST_SET_ADDR;
            o_busy <= 1'b1;
          end
        end
        ST_SET_ADDR: state <= ST_SEND;
        ST_SEND: begin
          if (ser_last) begin
            if (last_word) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
              state  <= ST_CHECKSUM;
`else
              state  <= ST_DONE;
              o_done <= 1'b1;
`endif
            end else begin
              // Address tracks idx*ADDR_STEP incrementally, wrapping at NB bits.
              idx             <= idx + 1'b1;
              o_debug_address <= o_debug_address + NB'(ADDR_STEP);
              state           <= ST_SET_ADDR;
            end
          end
        end
        ST_CHECKSUM: begin
          if (ser_xfer) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state           <= ST_IDLE;
          o_done          <= 1'b0;
          o_busy          <= 1'b0;
          idx             <= '0;
          o_debug_address <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_memory_dumper.sv
// Bench for debug_memory_dumper (NB=32, TAM=4, ADDR_STEP=4) with a scoreboard of bytes and addresses.
module tb_debug_memory_dumper;

  localparam int NB        = 32;
  localparam int TAM       = 4;
  localparam int ADDR_STEP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NB-1:0] debug_address;
  logic [NB-1:0] debug_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;
  int xfer_cnt = 0;
  bit rand_ready = 1'b0;
  logic [7:0]    exp_q[$];
  logic [NB-1:0] addr_q[$];

  debug_memory_dumper #(.NB(NB), .TAM(TAM), .ADDR_STEP(ADDR_STEP)) dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_start         (start),
    .o_debug_address (debug_address),
    .i_debug_data    (debug_data),
    .o_tx_data       (tx_data),
    .o_tx_valid      (tx_valid),
    .i_tx_ready      (tx_ready),
    .o_busy          (busy),
    .o_done          (done)
  );

  // Memory model: byte address -> word 0x11223344 + word index.
  assign debug_data = 32'h11223344 + (debug_address >> 2);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_dump();
    logic [31:0] w;
    logic [7:0]  chk;
    chk = 8'h00;
    for (int i = 0; i < TAM; i++) begin
      w = 32'h11223344 + 32'(i);
      addr_q.push_back(NB'(i * ADDR_STEP));
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[b*8 +: 8]);
        chk = chk ^ w[b*8 +: 8];
      end
    end
`ifdef DEBUG_DUMP_CHECKSUM_EN
    exp_q.push_back(chk);
`endif
  endtask

  // Drives a one-cycle start; returns at #1 after the sampling edge t0.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // n counts cycles after t0 (n=1 right after the start edge).
  task automatic wait_done(input int budget, output int n);
    n = 1;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  // Scoreboard monitors, sampled on the falling edge.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
        else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (busy && !tx_valid && !done) begin
        if (addr_q.size() == 0) check("unexpected_addr", debug_address, 32'hFFFF_FFFF);
        else check("set_addr", debug_address, addr_q.pop_front());
      end
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
    end
  end

  initial begin
    int n;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    int extra = 1;
`else
    int extra = 0;
`endif
    rst_n    = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b1;
    repeat (3) tick();
    check("rst_addr", debug_address, 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full dump with ready held high: exact latency and one-cycle done.
    push_dump();
    pulse_start();
    check("busy_t0p1", 32'(busy), 32'd1);
    check("valid_t0p1", 32'(tx_valid), 32'd0);
    tick();
    check("valid_t0p2", 32'(tx_valid), 32'd1);
    n = 2;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("done_cycle", 32'(n), 32'(21 + extra));
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("queue_empty1", 32'(exp_q.size()), 32'd0);

    // Random backpressure: same stream, outputs stable while stalled.
    rand_ready = 1'b1;
    push_dump();
    pulse_start();
    wait_done(400, n);
    rand_ready = 1'b0;
    tx_ready   = 1'b1;
    tick();
    check("queue_empty2", 32'(exp_q.size()), 32'd0);
    check("addr_empty2", 32'(addr_q.size()), 32'd0);

    // Reset while byte 2 of word 1 is on the link.
    xfer_cnt = 0;
    push_dump();
    pulse_start();
    n = 0;
    while (xfer_cnt < 6 && n < 100) begin
      tick();
      n++;
    end
    check("reach_byte6", 32'(xfer_cnt), 32'd6);
    rst_n = 1'b0;
    #1;
    check("midrst_addr", debug_address, 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    exp_q.delete();
    addr_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    push_dump();
    pulse_start();
    wait_done(100, n);
    check("post_rst_done_cycle", 32'(n), 32'(21 + extra));
    tick();

    // Start pulsed mid-dump and then held through DONE.
    push_dump();
    pulse_start();
    repeat (7) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    n = 12;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check("held_done_cycle", 32'(n), 32'(21 + extra));
    push_dump();
    tick();
    check("held_idle_busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    wait_done(100, n);
    check("restart_done_cycle", 32'(n), 32'(21 + extra));
    tick();
    tick();
    check("queue_empty_end", 32'(exp_q.size()), 32'd0);
    check("addr_empty_end", 32'(addr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
